nco_sweep_controller: RTL and testbench
=======================================

# nco_sweep_controller

Sequencer for the LUT sine generator. Generates its `sample_clk_ce` strobe from a programmable clock divider. Drives its `phase_increment` through a linear frequency sweep: start value, signed step, step count, and a dwell in samples per step. It sits between the register/control interface and the sine generator, and is used for chirp/sweep test signals and frequency-hop stimulus.

## Interface
- `PHASE_WIDTH`, 64, width of the phase increment; matches the generator.
- `DIV_WIDTH`, 16, width of the sample-rate divider.
- `CNT_WIDTH`, 16, width of the step count and dwell fields.

Ports:
- `clk`  in  1  clock.
- `arst`  in  1  reset, asynchronous, active-high.
- `ce_div`  in  DIV_WIDTH  sample period minus 1, in clk cycles.
- `start`  in  1  begin sweep; sampled only in IDLE.
- `abort`  in  1  stop sweep immediately.
- `f_start`  in  PHASE_WIDTH  first phase increment.
- `f_step`  in  PHASE_WIDTH, signed  increment added per step.
- `step_count`  in  CNT_WIDTH  number of steps after the first; the sweep has `step_count`+1 frequencies.
- `dwell`  in  CNT_WIDTH  samples per frequency; 0 is treated as 1.
- `sample_clk_ce`  out  1  sample strobe to the generator.
- `phase_increment`  out  PHASE_WIDTH, signed  increment to the generator.
- `step_index`  out  CNT_WIDTH  current step number.
- `busy`  out  1  sweep in progress.
- `done`  out  1  one-cycle pulse when a sweep completes.

## Operation
- **Divider**
  - Free-running counter from 0 to `ce_div`; it runs in every state.
  - `sample_clk_ce` is registered and is high for one cycle when the counter equals `ce_div`; the counter wraps to 0 on that cycle.
  - If `ce_div` is lowered below the current count (counter ≥ `ce_div`), the strobe fires next cycle and the counter wraps.
- **FSM states:** IDLE, RUN, FIN.
- **IDLE**
  - `start`=1 and `abort`=0 → RUN.
  - Latch `f_step`, `step_count` and `max(dwell,1)`.
  - Load `phase_increment`←`f_start`, `step_index`←0, dwell counter←latched dwell.
- **RUN**
  - Each `sample_clk_ce` decrements the dwell counter.
  - On the strobe where the dwell counter equals 1:
    - If `step_index` == latched `step_count` → FIN.
    - Otherwise `phase_increment` += `f_step` (wraps modulo 2^PHASE_WIDTH), `step_index`++, and the dwell counter reloads.
- **FIN:** `done`=1 for this cycle only, then → IDLE.
- **Outputs in IDLE:** `phase_increment` and `step_index` hold their last values, so the generator keeps running at the final frequency.
- **abort**
  - In any state → IDLE on the next edge. No `done` is produced; `phase_increment` is held.
  - `abort` wins over `start` in the same cycle.
- `start` while `busy`=1 is ignored.
- Input changes during RUN have no effect except `ce_div`, which is used live.

## Timing
- **Reset values:** `sample_clk_ce`=0, `phase_increment`=0, `step_index`=0, `busy`=0, `done`=0, divider=0, state IDLE.
- **Sweep start**
  - `start` sampled at edge t → `busy`=1 and `phase_increment`=`f_start` visible after edge t.
  - A strobe asserted in the same cycle as `start` is not counted.
- **Step change timing**
  - A step update happens on the strobe cycle itself.
  - The generator therefore uses the old increment on that strobe and the new one from the next strobe.
- **Sweep length:** exactly (`step_count`+1)·max(`dwell`,1) strobes.
- **Completion**
  - The final strobe moves the FSM to FIN. `done`=1 and `busy`=0 in the cycle after it; `busy` stays 0 afterwards.
- **`arst` mid-sweep:** all outputs return to reset values immediately, asynchronously.

## Configuration
- **`NCO_SWEEP_LOOP_EN` defined**
  - Adds input `loop_en` (1 bit).
  - If `loop_en`=1 at the end of the final step: `done` pulses for one cycle, `busy` stays 1, and `phase_increment`←`f_start` (live value), `step_index`←0, dwell counter reloads. The sweep repeats until `abort` or `loop_en`=0 at a sweep end.
- **Not defined:** no `loop_en` port; sweeps are always single-shot.

## Test plan
- `ce_div`=3, idle → `sample_clk_ce` high 1 cycle in every 4; first strobe 4 cycles after reset release.
- `ce_div`=0, `f_start`=100, `f_step`=10, `step_count`=2, `dwell`=2, `start` → `phase_increment` 100,100,110,110,120,120 across strobes; `done` 1 cycle after the 6th strobe; `phase_increment` holds 120.
- `f_start`=5, `f_step`=−10, `step_count`=1, `dwell`=0 → 5 for 1 strobe, then 2^64−5 (−5); `done` after 2 strobes.
- `abort` during step 1 of a 4-step sweep → `busy`=0 next cycle, no `done`, `phase_increment` holds its step-1 value; a second `start` while busy is ignored.
- `arst` pulsed mid-sweep → all outputs 0 immediately; a new `start` afterwards sweeps from `f_start` correctly.
- With `NCO_SWEEP_LOOP_EN`, `loop_en`=1, `step_count`=1, `dwell`=1 → `done` every 2 strobes, `busy` stays 1; drop `loop_en` → stops after the current lap.

Source files
------------

// File: rtl/nco_sweep_controller.sv
// Sweep sequencer for the LUT sine generator: sample-rate divider plus a
// linear phase-increment sweep FSM. Optional looping is enabled by NCO_SWEEP_LOOP_EN.
module nco_sweep_controller #(
    parameter int PHASE_WIDTH = 64,
    parameter int DIV_WIDTH   = 16,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                          clk,
    input  logic                          arst,
    input  logic [DIV_WIDTH-1:0]          ce_div,
    input  logic                          start,
    input  logic                          abort,
`ifdef NCO_SWEEP_LOOP_EN
    input  logic                          loop_en,
`endif
    input  logic [PHASE_WIDTH-1:0]        f_start,
    input  logic signed [PHASE_WIDTH-1:0] f_step,
    input  logic [CNT_WIDTH-1:0]          step_count,
    input  logic [CNT_WIDTH-1:0]          dwell,
    output logic                          sample_clk_ce,
    output logic signed [PHASE_WIDTH-1:0] phase_increment,
    output logic [CNT_WIDTH-1:0]          step_index,
    output logic                          busy,
    output logic                          done
);

    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    localparam logic [DIV_WIDTH-1:0] DIV_ONE = 1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = 1;

    state_t                          state;
    logic [DIV_WIDTH-1:0]            div_cnt;
    logic signed [PHASE_WIDTH-1:0]   step_q;
    logic [CNT_WIDTH-1:0]            count_q;
    logic [CNT_WIDTH-1:0]            dwell_q;
    logic [CNT_WIDTH-1:0]            dwell_cnt;
    logic [CNT_WIDTH-1:0]            dwell_eff;
    logic                            loop_go;

    assign dwell_eff = (dwell == '0) ? CNT_ONE : dwell;

`ifdef NCO_SWEEP_LOOP_EN
    assign loop_go = loop_en;
`else
    assign loop_go = 1'b0;
`endif

    // The >= compare lets a live reduction of ce_div take effect at once.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            div_cnt       <= '0;
            sample_clk_ce <= 1'b0;
        end else if (div_cnt >= ce_div) begin
            div_cnt       <= '0;
            sample_clk_ce <= 1'b1;
        end else begin
            div_cnt       <= div_cnt + DIV_ONE;
            sample_clk_ce <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state           <= IDLE;
            phase_increment <= '0;
            step_index      <= '0;
            busy            <= 1'b0;
            done            <= 1'b0;
            step_q          <= '0;
            count_q         <= '0;
            dwell_q         <= '0;
            dwell_cnt       <= '0;
        end else begin
            done <= 1'b0;
            if (abort) begin
                state <= IDLE;
                busy  <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            state           <= RUN;
                            busy            <= 1'b1;
                            step_q          <= f_step;
                            count_q         <= step_count;
                            dwell_q         <= dwell_eff;
                            dwell_cnt       <= dwell_eff;
                            phase_increment <= f_start;
                            step_index      <= '0;
                        end
                    end
                    RUN: begin
                        // Updates land on the strobe cycle, so the generator sees
                        // the new increment from the following strobe onwards.
                        if (sample_clk_ce) begin
                            if (dwell_cnt == CNT_ONE) begin
                                if (step_index == count_q) begin
                                    done <= 1'b1;
                                    if (loop_go) begin
                                        phase_increment <= f_start;
                                        step_index      <= '0;
                                        dwell_cnt       <= dwell_q;
                                    end else begin
                                        state <= FIN;
                                        busy  <= 1'b0;
                                    end
                                end else begin
                                    phase_increment <= phase_increment + step_q;
                                    step_index      <= step_index + CNT_ONE;
                                    dwell_cnt       <= dwell_q;
                                end
                            end else begin
                                dwell_cnt <= dwell_cnt - CNT_ONE;
                            end
                        end
                    end
                    FIN: begin
                        state <= IDLE;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_nco_sweep_controller.sv
// Directed self-checking bench for nco_sweep_controller: divider cadence,
// sweeps with positive/negative steps, abort, async reset, live ce_div change.
module tb_nco_sweep_controller;

    logic        clk;
    logic        arst;
    logic [15:0] ce_div;
    logic        start;
    logic        abort;
`ifdef NCO_SWEEP_LOOP_EN
    logic        loop_en;
`endif
    logic [63:0] f_start;
    logic [63:0] f_step;
    logic [15:0] step_count;
    logic [15:0] dwell;
    logic        sample_clk_ce;
    logic [63:0] phase_increment;
    logic [15:0] step_index;
    logic        busy;
    logic        done;

    int vectors;
    int miscompares;

    nco_sweep_controller dut (
        .clk             (clk),
        .arst            (arst),
        .ce_div          (ce_div),
        .start           (start),
        .abort           (abort),
`ifdef NCO_SWEEP_LOOP_EN
        .loop_en         (loop_en),
`endif
        .f_start         (f_start),
        .f_step          (f_step),
        .step_count      (step_count),
        .dwell           (dwell),
        .sample_clk_ce   (sample_clk_ce),
        .phase_increment (phase_increment),
        .step_index      (step_index),
        .busy            (busy),
        .done            (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [15:0] div, input logic [63:0] fs, input logic [63:0] fst,
                                 input logic [15:0] sc, input logic [15:0] dw);
        ce_div     = div;
        f_start    = fs;
        f_step     = fst;
        step_count = sc;
        dwell      = dw;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic pulseStart();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    logic [63:0] exp_phase [6];
    logic        done_seen;

    initial begin
        vectors     = 0;
        miscompares = 0;
        arst        = 1'b1;
        start       = 1'b0;
        abort       = 1'b0;
`ifdef NCO_SWEEP_LOOP_EN
        loop_en     = 1'b0;
`endif
        applyStimulus(16'd3, 64'd0, 64'd0, 16'd0, 16'd0);
        exp_phase = '{64'd100, 64'd100, 64'd110, 64'd110, 64'd120, 64'd120};

        // Reset state
        repeat (3) @(negedge clk);
        checkOutput("rst_ce", {63'd0, sample_clk_ce}, 64'd0);
        checkOutput("rst_phase", phase_increment, 64'd0);
        checkOutput("rst_step", {48'd0, step_index}, 64'd0);
        checkOutput("rst_busy", {63'd0, busy}, 64'd0);
        checkOutput("rst_done", {63'd0, done}, 64'd0);
        arst = 1'b0;

        // ce_div=3: strobe every 4th cycle, first after the 4th edge
        for (int i = 0; i < 8; i++) begin
            tick();
            checkOutput($sformatf("div3_ce_%0d", i), {63'd0, sample_clk_ce}, {63'd0, (i % 4) == 3});
        end

        // Positive sweep: 100,100,110,110,120,120
        $display("[TB] positive sweep");
        applyStimulus(16'd0, 64'd100, 64'd10, 16'd2, 16'd2);
        pulseStart();
        checkOutput("sw1_busy_start", {63'd0, busy}, 64'd1);
        checkOutput("sw1_step_start", {48'd0, step_index}, 64'd0);
        for (int k = 0; k < 6; k++) begin
            checkOutput($sformatf("sw1_ce_%0d", k), {63'd0, sample_clk_ce}, 64'd1);
            checkOutput($sformatf("sw1_phase_%0d", k), phase_increment, exp_phase[k]);
            checkOutput($sformatf("sw1_done_%0d", k), {63'd0, done}, 64'd0);
            tick();
        end
        checkOutput("sw1_done", {63'd0, done}, 64'd1);
        checkOutput("sw1_busy_end", {63'd0, busy}, 64'd0);
        checkOutput("sw1_phase_end", phase_increment, 64'd120);
        checkOutput("sw1_step_end", {48'd0, step_index}, 64'd2);
        tick();
        checkOutput("sw1_done_clr", {63'd0, done}, 64'd0);
        checkOutput("sw1_phase_hold", phase_increment, 64'd120);

        // Negative step with dwell=0 treated as 1
        $display("[TB] negative step sweep");
        applyStimulus(16'd0, 64'd5, 64'hFFFF_FFFF_FFFF_FFF6, 16'd1, 16'd0);
        pulseStart();
        checkOutput("sw2_phase0", phase_increment, 64'd5);
        tick();
        checkOutput("sw2_phase1", phase_increment, 64'hFFFF_FFFF_FFFF_FFFB);
        checkOutput("sw2_busy_mid", {63'd0, busy}, 64'd1);
        checkOutput("sw2_done_mid", {63'd0, done}, 64'd0);
        tick();
        checkOutput("sw2_done", {63'd0, done}, 64'd1);
        checkOutput("sw2_busy_end", {63'd0, busy}, 64'd0);
        checkOutput("sw2_phase_end", phase_increment, 64'hFFFF_FFFF_FFFF_FFFB);
        tick();

        // Abort during step 1; restart while busy is ignored
        $display("[TB] abort sweep");
        applyStimulus(16'd0, 64'd1000, 64'd1, 16'd3, 16'd3);
        pulseStart();
        tick();
        tick();
        tick();
        checkOutput("ab_step1", {48'd0, step_index}, 64'd1);
        checkOutput("ab_phase1", phase_increment, 64'd1001);
        f_start = 64'd7;
        pulseStart();
        checkOutput("ab_restart_phase", phase_increment, 64'd1001);
        checkOutput("ab_restart_step", {48'd0, step_index}, 64'd1);
        checkOutput("ab_restart_busy", {63'd0, busy}, 64'd1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checkOutput("ab_busy", {63'd0, busy}, 64'd0);
        checkOutput("ab_done", {63'd0, done}, 64'd0);
        checkOutput("ab_phase_hold", phase_increment, 64'd1001);
        done_seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            done_seen = done_seen | done;
        end
        checkOutput("ab_no_done", {63'd0, done_seen}, 64'd0);
        checkOutput("ab_phase_hold2", phase_increment, 64'd1001);

        // Asynchronous reset mid-sweep, then a clean restart
        $display("[TB] async reset mid-sweep");
        applyStimulus(16'd0, 64'd50, 64'd5, 16'd5, 16'd2);
        pulseStart();
        tick();
        tick();
        checkOutput("ar_pre_phase", phase_increment, 64'd55);
        arst = 1'b1;
        #1;
        checkOutput("ar_phase", phase_increment, 64'd0);
        checkOutput("ar_step", {48'd0, step_index}, 64'd0);
        checkOutput("ar_busy", {63'd0, busy}, 64'd0);
        checkOutput("ar_ce", {63'd0, sample_clk_ce}, 64'd0);
        checkOutput("ar_done", {63'd0, done}, 64'd0);
        @(negedge clk);
        arst = 1'b0;
        pulseStart();
        checkOutput("ar_restart_phase", phase_increment, 64'd50);
        checkOutput("ar_restart_busy", {63'd0, busy}, 64'd1);
        tick();
        tick();
        checkOutput("ar_step_phase", phase_increment, 64'd55);
        checkOutput("ar_step_idx", {48'd0, step_index}, 64'd1);
        abort = 1'b1;
        tick();
        abort = 1'b0;

        // Lowering ce_div below the running count forces a strobe next cycle
        $display("[TB] live ce_div reduction");
        arst = 1'b1;
        ce_div = 16'd9;
        @(negedge clk);
        arst = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        checkOutput("div_low_pre", {63'd0, sample_clk_ce}, 64'd0);
        ce_div = 16'd2;
        tick();
        checkOutput("div_low_fire", {63'd0, sample_clk_ce}, 64'd1);
        tick();
        checkOutput("div_low_c1", {63'd0, sample_clk_ce}, 64'd0);
        tick();
        checkOutput("div_low_c2", {63'd0, sample_clk_ce}, 64'd0);
        tick();
        checkOutput("div_low_c3", {63'd0, sample_clk_ce}, 64'd1);

`ifdef NCO_SWEEP_LOOP_EN
        $display("[TB] looping sweep");
        loop_en = 1'b1;
        applyStimulus(16'd0, 64'd200, 64'd1, 16'd1, 16'd1);
        pulseStart();
        checkOutput("lp_phase0", phase_increment, 64'd200);
        tick();
        checkOutput("lp_phase1", phase_increment, 64'd201);
        tick();
        checkOutput("lp_done1", {63'd0, done}, 64'd1);
        checkOutput("lp_busy1", {63'd0, busy}, 64'd1);
        checkOutput("lp_phase_wrap", phase_increment, 64'd200);
        loop_en = 1'b0;
        tick();
        checkOutput("lp_done_clr", {63'd0, done}, 64'd0);
        checkOutput("lp_phase2", phase_increment, 64'd201);
        tick();
        checkOutput("lp_done2", {63'd0, done}, 64'd1);
        checkOutput("lp_busy2", {63'd0, busy}, 64'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
